// File: rtl/psum_ofifo_if.sv
// Handshake/data bundle between the MAC column array, psum_ofifo and its reader.
interface psum_ofifo_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned bw_psum = 22
);
    logic [col-1:0]         wr;
    logic [col*bw_psum-1:0] in;
    logic                   rd;
    logic                   flush;
    logic [col*bw_psum-1:0] out;
    logic                   out_vld;
    logic                   o_valid;
    logic                   o_full;
    logic                   overflow;

    modport master (output wr, in, rd, flush,
                    input  out, out_vld, o_valid, o_full, overflow);
    modport slave  (input  wr, in, rd, flush,
                    output out, out_vld, o_valid, o_full, overflow);
endinterface

// File: rtl/psum_ofifo.sv
// Per-lane circular buffers that absorb systolic column skew; rows are popped in lockstep
// once every lane holds at least one psum.
module psum_ofifo #(
    parameter int unsigned col     = 8,
    parameter int unsigned bw_psum = 22,
    parameter int unsigned depth   = 16,
    parameter int unsigned aw      = 4
) (
    input  logic          clk,
    input  logic          reset,
    psum_ofifo_if.slave   bus
);
    localparam int unsigned CW = aw + 1;
    localparam int unsigned W  = col * bw_psum;

    logic [bw_psum-1:0] mem [col][depth];
    logic [aw-1:0]      wp  [col];
    logic [CW-1:0]      cnt [col];
    logic [aw-1:0]      rp;

    logic [col-1:0] lane_ne_c;
    logic [col-1:0] lane_full_c;
    logic [col-1:0] wr_ok_c;
    logic           o_valid_c;
    logic           pop_c;
    logic [W-1:0]   row_c;

    // Lane status and the row addressed by the shared read pointer.
    always_comb begin
        lane_ne_c   = '0;
        lane_full_c = '0;
        row_c       = '0;
        for (int i = 0; i < col; i++) begin
            lane_ne_c[i]                 = (cnt[i] != '0);
            lane_full_c[i]               = (cnt[i] == CW'(depth));
            row_c[i*bw_psum +: bw_psum]  = mem[i][rp];
        end
    end

    assign o_valid_c    = &lane_ne_c;
    assign bus.o_valid  = o_valid_c;
    assign bus.o_full   = |lane_full_c;
    assign pop_c        = bus.rd && o_valid_c && !bus.flush;
    // A full lane still accepts a write when the same cycle pops a row out of it.
    assign wr_ok_c      = bus.wr & ~{col{bus.flush}} & (~lane_full_c | {col{pop_c}});

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_ok_c[i]) begin
                mem[i][wp[i]] <= bus.in[i*bw_psum +: bw_psum];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) begin
                wp[i]  <= '0;
                cnt[i] <= '0;
            end
            rp           <= '0;
            bus.out      <= '0;
            bus.out_vld  <= 1'b0;
            bus.overflow <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < col; i++) begin
                wp[i]  <= '0;
                cnt[i] <= '0;
            end
            rp           <= '0;
            bus.out      <= '0;
            bus.out_vld  <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_ok_c[i]) begin
                    wp[i] <= wp[i] + aw'(1);
                end
                if (wr_ok_c[i] && !pop_c) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!wr_ok_c[i] && pop_c) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
            if (pop_c) begin
                rp      <= rp + aw'(1);
                bus.out <= row_c;
            end
            bus.out_vld <= pop_c;
            if (|(bus.wr & lane_full_c & ~{col{pop_c}})) begin
                bus.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: table of vectors plus hand sequences, all checked against a
// per-lane queue model and a scoreboard of expected popped rows.
module tb_psum_ofifo;
    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 22;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned W     = COL * BW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_ofifo_if #(.col(COL), .bw_psum(BW)) bus ();

    psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH), .aw(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [BW-1:0] lq [COL][$];
    logic [W-1:0]  sb [$];
    logic [W-1:0]  last_out;
    logic          m_ovf;
    logic          m_vld;
    int            n_vec;
    int            n_err;

    typedef struct {
        logic [COL-1:0] wr;
        logic           rd;
        logic           flush;
        int             base;
        logic           e_valid;
        logic           e_full;
        logic           e_ovf;
        logic           e_vld;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic m_valid();
        logic v = 1'b1;
        for (int i = 0; i < COL; i++) if (lq[i].size() == 0) v = 1'b0;
        return v;
    endfunction

    function automatic logic m_full();
        logic f = 1'b0;
        for (int i = 0; i < COL; i++) if (lq[i].size() == DEPTH) f = 1'b1;
        return f;
    endfunction

    function automatic logic [W-1:0] rowv(input int base);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(base + i);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < COL; i++) lq[i].delete();
        sb.delete();
        m_ovf    = 1'b0;
        m_vld    = 1'b0;
        last_out = '0;
    endtask

    // One clock: update the model, drive the DUT, compare after the edge.
    task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d,
                        input logic r, input logic f);
        logic         pop;
        logic [W-1:0] row;
        bus.wr = w; bus.in = d; bus.rd = r; bus.flush = f;
        if (f) begin
            model_clear();
        end else begin
            pop = r && m_valid();
            if (pop) begin
                for (int i = 0; i < COL; i++) row[i*BW +: BW] = lq[i].pop_front();
                sb.push_back(row);
            end
            m_vld = pop;
            for (int i = 0; i < COL; i++) begin
                if (w[i]) begin
                    if (lq[i].size() < DEPTH) lq[i].push_back(d[i*BW +: BW]);
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_vld", W'(bus.out_vld), W'(m_vld));
        if (m_vld && sb.size() > 0) last_out = sb.pop_front();
        chk("out", bus.out, last_out);
        chk("o_valid", W'(bus.o_valid), W'(m_valid()));
        chk("o_full", W'(bus.o_full), W'(m_full()));
        chk("overflow", W'(bus.overflow), W'(m_ovf));
        bus.wr = '0; bus.rd = 1'b0; bus.flush = 1'b0;
    endtask

    initial begin
        logic [W-1:0] e3;
        n_vec = 0;
        n_err = 0;
        model_clear();
        reset = 1'b0;
        bus.wr = '0; bus.in = '0; bus.rd = 1'b0; bus.flush = 1'b0;

        tbl[0] = '{8'h00, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h0F, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'hF0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 30, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b1, 1'b0, 40, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{8'hFF, 1'b0, 1'b1, 50, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{8'h00, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", W'(bus.o_valid), '0);
        chk("rst_o_full", W'(bus.o_full), '0);
        chk("rst_out", bus.out, '0);
        chk("rst_out_vld", W'(bus.out_vld), '0);
        chk("rst_overflow", W'(bus.overflow), '0);
        reset = 1'b1;

        for (int k = 0; k < 10; k++) begin
            step(tbl[k].wr, rowv(tbl[k].base), tbl[k].rd, tbl[k].flush);
            chk($sformatf("tbl%0d_valid", k), W'(bus.o_valid), W'(tbl[k].e_valid));
            chk($sformatf("tbl%0d_full", k), W'(bus.o_full), W'(tbl[k].e_full));
            chk($sformatf("tbl%0d_ovf", k), W'(bus.overflow), W'(tbl[k].e_ovf));
            chk($sformatf("tbl%0d_vld", k), W'(bus.out_vld), W'(tbl[k].e_vld));
        end

        // Skewed fill: lane i written alone, one cycle apart.
        for (int i = 0; i < COL; i++) step(COL'(1) << i, rowv(100), 1'b0, 1'b0);
        chk("skew_valid", W'(bus.o_valid), W'(1));
        step('0, '0, 1'b1, 1'b0);
        chk("skew_row", bus.out, rowv(100));

        // Signed data kept bit-exact.
        e3 = '0;
        e3[3*BW +: BW] = '1;
        step('1, e3, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        chk("signed_row", bus.out, e3);

        // Fill to full, drop one write on lane 5, then drain in order.
        for (int k = 0; k < DEPTH; k++) step('1, rowv(1000 + k*COL), 1'b0, 1'b0);
        chk("full_o_full", W'(bus.o_full), W'(1));
        step(8'h20, rowv(5000), 1'b0, 1'b0);
        chk("full_overflow", W'(bus.overflow), W'(1));
        for (int k = 0; k < DEPTH; k++) begin
            step('0, '0, 1'b1, 1'b0);
            chk($sformatf("drain%0d", k), bus.out, rowv(1000 + k*COL));
        end
        chk("drained_valid", W'(bus.o_valid), '0);

        // Full with simultaneous pop and write, pointers wrapping.
        step('0, '0, 1'b0, 1'b1);
        for (int k = 0; k < DEPTH; k++) step('1, rowv(2000 + k*COL), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step('1, rowv(3000 + k*COL), 1'b1, 1'b0);
            chk($sformatf("thru%0d_full", k), W'(bus.o_full), W'(1));
            chk($sformatf("thru%0d_ovf", k), W'(bus.overflow), '0);
        end

        // Flush with rows buffered, overflow set and a same-cycle write.
        step(8'h01, rowv(4000), 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) step('0, '0, 1'b1, 1'b0);
        chk("pre_flush_ovf", W'(bus.overflow), W'(1));
        step('1, rowv(4100), 1'b0, 1'b1);
        chk("flush_valid", W'(bus.o_valid), '0);
        chk("flush_ovf", W'(bus.overflow), '0);
        step('0, '0, 1'b1, 1'b0);
        chk("flush_no_pop", W'(bus.out_vld), '0);

        // Asynchronous reset mid-stream, after a pop left out/out_vld non-zero.
        for (int k = 0; k < 3; k++) step('1, rowv(200 + k*COL), 1'b0, 1'b0);
        step(8'h0F, rowv(260), 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("arst_o_valid", W'(bus.o_valid), '0);
        chk("arst_out", bus.out, '0);
        chk("arst_out_vld", W'(bus.out_vld), '0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step('1, rowv(300), 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        chk("post_rst_row", bus.out, rowv(300));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
